bank_cmd_queue: RTL and testbench

Per-bank command FIFO bank that feeds the command scheduler's round-robin arbiter. Each bank holds up to DEPTH pending commands. The block presents each bank's head entry on cmd_queue and its non-empty status on queue_valid. It pops a bank's head when the arbiter reports that bank selected (active-low sel_bank) for a non-NOP issue. It sits between the request decoder (push side) and the arbiter (pop side).

---
 rtl/bank_cmd_queue.sv | 121 ++++++++++++
 tb/tb_bank_cmd_queue.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : bank_cmd_queue
// Brief    : Per-bank command FIFOs feeding the scheduler arbiter; heads and
//            non-empty status are exposed per bank, pops come from sel_bank.
// Revision : 1.0 - initial release
// ============================================================================
module bank_cmd_queue #(
    parameter int NUM_BNK_TOT = 16,
    parameter int QWIDTH      = 32,
    parameter int DEPTH       = 4,
    parameter int BANK_W      = $clog2(NUM_BNK_TOT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_valid,
    input  logic [BANK_W-1:0]             push_bank,
    input  logic [QWIDTH-1:0]             push_cmd,
    output logic                          push_ready,
    output logic [NUM_BNK_TOT*QWIDTH-1:0] cmd_queue,
    output logic [NUM_BNK_TOT-1:0]        queue_valid,
    input  logic [NUM_BNK_TOT-1:0]        sel_bank,
    input  logic                          issue_valid,
    output logic [NUM_BNK_TOT-1:0]        bank_full,
    output logic                          pop_err
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [NUM_BNK_TOT-1:0] w_sel;
    logic                   w_sel_onehot;
    logic                   w_sel_empty;
    logic                   w_pop_ok;
    logic                   w_push_ok;
    logic                   pop_err_q;
    logic                   pop_err_d;

    // sel_bank is active-low; invert so a legal selection is one-hot.
    assign w_sel        = ~sel_bank;
    assign w_sel_onehot = (w_sel != '0) &&
                          ((w_sel & (w_sel - NUM_BNK_TOT'(1))) == '0);
    assign w_sel_empty  = |(w_sel & ~queue_valid);
    assign w_pop_ok     = issue_valid & w_sel_onehot & ~w_sel_empty;

    assign push_ready   = ~bank_full[push_bank];
    assign w_push_ok    = push_valid & push_ready;

    always_comb begin
        pop_err_d = pop_err_q;
        if (issue_valid && (!w_sel_onehot || w_sel_empty)) begin
            pop_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_err_q <= 1'b0;
        end else begin
            pop_err_q <= pop_err_d;
        end
    end

    assign pop_err = pop_err_q;

    for (genvar b = 0; b < NUM_BNK_TOT; b++) begin : g_bank
        localparam logic [BANK_W-1:0] c_ID = BANK_W'(b);

        logic [QWIDTH-1:0]  mem_q [DEPTH];
        logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
        logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
        logic [c_CNT_W-1:0] count_q, count_d;
        logic               w_push;
        logic               w_pop;

        assign w_push = w_push_ok && (push_bank == c_ID);
        assign w_pop  = w_pop_ok && w_sel[b];

        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_CNT_W'(1);
                2'b01:   count_d = count_q - c_CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage is deliberately not reset; the head mux masks stale data.
        always_ff @(posedge clk) begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= push_cmd;
            end
        end

        assign queue_valid[b] = (count_q != '0);
        assign bank_full[b]   = (count_q == c_CNT_W'(DEPTH));
        assign cmd_queue[b*QWIDTH +: QWIDTH] = queue_valid[b] ? mem_q[rd_ptr_q] : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_bank_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_bank_cmd_queue
// Brief    : Directed self-checking bench for bank_cmd_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bank_cmd_queue;

    localparam int NB = 16;
    localparam int QW = 32;
    localparam int DP = 4;
    localparam int BW = 4;

    logic              clk;
    logic              rst;
    logic              push_valid;
    logic [BW-1:0]     push_bank;
    logic [QW-1:0]     push_cmd;
    logic              push_ready;
    logic [NB*QW-1:0]  cmd_queue;
    logic [NB-1:0]     queue_valid;
    logic [NB-1:0]     sel_bank;
    logic              issue_valid;
    logic [NB-1:0]     bank_full;
    logic              pop_err;

    int vectors;
    int miscompares;

    bank_cmd_queue #(
        .NUM_BNK_TOT(NB),
        .QWIDTH     (QW),
        .DEPTH      (DP),
        .BANK_W     (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_bank  (push_bank),
        .push_cmd   (push_cmd),
        .push_ready (push_ready),
        .cmd_queue  (cmd_queue),
        .queue_valid(queue_valid),
        .sel_bank   (sel_bank),
        .issue_valid(issue_valid),
        .bank_full  (bank_full),
        .pop_err    (pop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [QW-1:0] head(input int b);
        return cmd_queue[b*QW +: QW];
    endfunction

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        push_valid  = 1'b0;
        push_bank   = '0;
        push_cmd    = '0;
        sel_bank    = '1;
        issue_valid = 1'b0;
    endtask

    task automatic push_one(input int b, input logic [QW-1:0] d);
        push_valid = 1'b1;
        push_bank  = BW'(b);
        push_cmd   = d;
        step();
        push_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) push_one(7, 32'h70 + i);
        issue_valid = 1'b1;
        sel_bank    = 16'hFFFF;
        step();
        issue_valid = 1'b0;
        vectors++;
        if (bank_full[7] !== 1'b1 || pop_err !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: full7=%b pop_err=%b exp 1 1", bank_full[7], pop_err);
        end
        #3;
        rst = 1'b1;
        #1;
        vectors++;
        if (queue_valid !== '0 || bank_full !== '0 || pop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: qv=%h full=%h err=%b exp 0 0 0", queue_valid, bank_full, pop_err);
        end
        vectors++;
        if (cmd_queue !== '0) begin
            miscompares++;
            $display("FAIL reset_heads: cmd_queue=%h exp 0", cmd_queue);
        end
        push_valid = 1'b1;
        for (int b = 0; b < NB; b++) begin
            push_bank = BW'(b);
            #1;
            vectors++;
            if (push_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_ready bank %0d: got %b exp 1", b, push_ready);
            end
        end
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        vectors++;
        if (queue_valid !== '0) begin
            miscompares++;
            $display("FAIL reset_discard: qv=%h exp 0", queue_valid);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_bank  = 4'd3;
            push_cmd   = 32'hA0 + i;
            #1;
            vectors++;
            if (push_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready %0d: got %b exp 1", i, push_ready);
            end
            step();
        end
        push_valid = 1'b0;
        vectors++;
        if (bank_full[3] !== 1'b1 || head(3) !== 32'hA0 || queue_valid[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_full: full=%b head=%h qv=%b exp 1 a0 1", bank_full[3], head(3), queue_valid[3]);
        end
        push_valid = 1'b1;
        push_cmd   = 32'hA4;
        #1;
        vectors++;
        if (push_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_refuse: push_ready=%b exp 0", push_ready);
        end
        step();
        push_valid = 1'b0;
        vectors++;
        if (head(3) !== 32'hA0 || bank_full[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_drop: head=%h full=%b exp a0 1", head(3), bank_full[3]);
        end
    endtask

    task automatic test_pop_order();
        logic [QW-1:0] exp_head [4];
        exp_head[0] = 32'hA1;
        exp_head[1] = 32'hA2;
        exp_head[2] = 32'hA3;
        exp_head[3] = 32'h0;
        sel_bank    = 16'hFFF7;
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (head(3) !== exp_head[i] || bank_full[3] !== 1'b0) begin
                miscompares++;
                $display("FAIL pop_order %0d: head=%h full=%b exp %h 0", i, head(3), bank_full[3], exp_head[i]);
            end
        end
        idle_inputs();
        vectors++;
        if (queue_valid[3] !== 1'b0 || pop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_empty: qv3=%b err=%b exp 0 0", queue_valid[3], pop_err);
        end
    endtask

    task automatic test_simul();
        push_one(5, 32'h11);
        vectors++;
        if (head(5) !== 32'h11) begin
            miscompares++;
            $display("FAIL simul_pre: head5=%h exp 11", head(5));
        end
        push_valid  = 1'b1;
        push_bank   = 4'd5;
        push_cmd    = 32'h22;
        sel_bank    = 16'hFFDF;
        issue_valid = 1'b1;
        step();
        push_valid  = 1'b0;
        issue_valid = 1'b0;
        vectors++;
        if (head(5) !== 32'h22 || queue_valid[5] !== 1'b1 || bank_full[5] !== 1'b0) begin
            miscompares++;
            $display("FAIL simul: head5=%h qv=%b full=%b exp 22 1 0", head(5), queue_valid[5], bank_full[5]);
        end
        issue_valid = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if (queue_valid[5] !== 1'b0 || pop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_drain: qv5=%b err=%b exp 0 0", queue_valid[5], pop_err);
        end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 10; i++) begin
            push_one(0, QW'(i));
            vectors++;
            if (head(0) !== QW'(i) || queue_valid[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL wrap_push %0d: head0=%h qv=%b exp %h 1", i, head(0), queue_valid[0], QW'(i));
            end
            sel_bank    = 16'hFFFE;
            issue_valid = 1'b1;
            step();
            idle_inputs();
            vectors++;
            if (queue_valid[0] !== 1'b0 || head(0) !== '0) begin
                miscompares++;
                $display("FAIL wrap_pop %0d: qv0=%b head0=%h exp 0 0", i, queue_valid[0], head(0));
            end
        end
    endtask

    task automatic test_err_multi();
        push_one(2, 32'h33);
        push_one(3, 32'h44);
        sel_bank = 16'hFFFB;
        step();
        vectors++;
        if (head(2) !== 32'h33 || pop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL no_issue: head2=%h err=%b exp 33 0", head(2), pop_err);
        end
        sel_bank    = 16'hFFF3;
        issue_valid = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if (pop_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_multi: pop_err=%b exp 1", pop_err);
        end
        vectors++;
        if (head(2) !== 32'h33 || head(3) !== 32'h44 || queue_valid[3:2] !== 2'b11) begin
            miscompares++;
            $display("FAIL err_multi_nopop: h2=%h h3=%h qv=%b exp 33 44 11", head(2), head(3), queue_valid[3:2]);
        end
    endtask

    task automatic test_err_empty();
        pulse_reset();
        vectors++;
        if (pop_err !== 1'b0 || queue_valid !== '0) begin
            miscompares++;
            $display("FAIL err_empty_pre: err=%b qv=%h exp 0 0", pop_err, queue_valid);
        end
        sel_bank    = 16'hFFFE;
        issue_valid = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if (pop_err !== 1'b1 || queue_valid !== '0) begin
            miscompares++;
            $display("FAIL err_empty: err=%b qv=%h exp 1 0", pop_err, queue_valid);
        end
        push_one(0, 32'h5A);
        sel_bank    = 16'hFFFE;
        issue_valid = 1'b1;
        step();
        idle_inputs();
        repeat (3) step();
        vectors++;
        if (pop_err !== 1'b1 || queue_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL err_sticky: err=%b qv0=%b exp 1 0", pop_err, queue_valid[0]);
        end
        pulse_reset();
        vectors++;
        if (pop_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: err=%b exp 0", pop_err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        test_reset();
        test_fill();
        test_pop_order();
        test_simul();
        test_wrap();
        test_err_multi();
        test_err_empty();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
